// File: rtl/shift_left_unit_if.sv
// Operand/result bundle for shift_left_unit; master drives operands, slave returns
// the registered result and its shifted-out flags.
interface shift_left_unit_if #(
  parameter int DATA_LEN = 32
);
  localparam int SHAMT_LEN = $clog2(DATA_LEN);

  logic                 i_valid;
  logic [DATA_LEN-1:0]  i_value;
  logic                 i_use_shamt;
  logic [SHAMT_LEN-1:0] i_shamt;
  logic                 o_valid;
  logic [DATA_LEN-1:0]  o_shifted;
  logic                 o_carry;
  logic                 o_lost;

  modport master (
    output i_valid, i_value, i_use_shamt, i_shamt,
    input  o_valid, o_shifted, o_carry, o_lost
  );

  modport slave (
    input  i_valid, i_value, i_use_shamt, i_shamt,
    output o_valid, o_shifted, o_carry, o_lost
  );
endinterface

// File: rtl/shift_left_unit.sv
// Registered logical left shifter (fixed or run-time amount) with carry/lost flags.
// Latency 1 cycle; no backpressure, one operand accepted every cycle.
module shift_left_unit #(
  parameter int DATA_LEN     = 32,
  parameter int POS_TO_SHIFT = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  shift_left_unit_if.slave  bus
);
  localparam int SHAMT_LEN = $clog2(DATA_LEN);
  localparam logic [DATA_LEN-1:0] ONE = DATA_LEN'(1);

  logic [SHAMT_LEN-1:0] amt;
  logic [DATA_LEN-1:0]  shifted_d, shifted_q;
  logic                 carry_d, carry_q;
  logic                 lost_d, lost_q;
  logic                 valid_d, valid_q;

  assign amt = bus.i_use_shamt ? bus.i_shamt : SHAMT_LEN'(POS_TO_SHIFT);

  // Each stage shifts by 2^k; the last stage that actually shifts owns the carry,
  // and once the cumulative amount reaches DATA_LEN its outgoing bits are all zero.
  always_comb begin
    shifted_d = bus.i_value;
    carry_d   = 1'b0;
    lost_d    = 1'b0;
    for (int k = 0; k < SHAMT_LEN; k++) begin
      if (amt[k]) begin
        carry_d   = |(shifted_d & (ONE << (DATA_LEN - (1 << k))));
        lost_d    = lost_d | (|(shifted_d >> (DATA_LEN - (1 << k))));
        shifted_d = shifted_d << (1 << k);
      end
    end
  end

  assign valid_d = bus.i_valid;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      shifted_q <= '0;
      carry_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (bus.i_valid) begin
        shifted_q <= shifted_d;
        carry_q   <= carry_d;
        lost_q    <= lost_d;
      end
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_shifted = shifted_q;
  assign bus.o_carry   = carry_q;
  assign bus.o_lost    = lost_q;
endmodule

// File: tb/tb_shift_left_unit.sv
// Directed-vector bench for shift_left_unit (DATA_LEN=32, POS_TO_SHIFT=2).
module tb_shift_left_unit;
  localparam int DATA_LEN = 32;

  logic i_clk;
  logic i_rst_n;
  int   n_checks;
  int   n_fails;

  shift_left_unit_if #(.DATA_LEN(DATA_LEN)) bus ();

  shift_left_unit #(
    .DATA_LEN(DATA_LEN),
    .POS_TO_SHIFT(2)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .bus(bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        use_shamt;
    logic [4:0]  shamt;
    logic [31:0] value;
    logic [31:0] exp_shifted;
    logic        exp_carry;
    logic        exp_lost;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic use_sh, input logic [4:0] sh,
                       input logic [31:0] val);
    bus.i_valid     = vld;
    bus.i_use_shamt = use_sh;
    bus.i_shamt     = sh;
    bus.i_value     = val;
  endtask

  task automatic chk_out(input string name, input logic vld, input logic [31:0] sh,
                         input logic c, input logic l);
    chk({name, ".valid"},   32'(bus.o_valid), 32'(vld));
    chk({name, ".shifted"}, bus.o_shifted,    sh);
    chk({name, ".carry"},   32'(bus.o_carry), 32'(c));
    chk({name, ".lost"},    32'(bus.o_lost),  32'(l));
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] e_s;
    logic        e_c;
    logic        e_l;
    n_checks = 0;
    n_fails  = 0;

    //            use sh  value         shifted       c     l
    vecs[0]  = '{1'b0, 5'd0,  32'h00000001, 32'h00000004, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h00000002, 32'h00000008, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0000FFFF, 32'h0003FFFC, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFC, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 5'd0,  32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 5'd0,  32'h80000001, 32'h80000001, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 5'd1,  32'h80000001, 32'h00000002, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 5'd31, 32'h80000001, 32'h80000000, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h40000000, 32'h00000000, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 5'd0,  32'h80000000, 32'h00000000, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 5'd4,  32'h12345678, 32'h23456780, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 5'd16, 32'h00000001, 32'h00010000, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 5'd16, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 5'd15, 32'h00018000, 32'hC0000000, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 5'd7,  32'h00000003, 32'h0000000C, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 5'd8,  32'h01000001, 32'h00000100, 1'b1, 1'b1};

    // Reset held for two cycles while valid operands are presented
    i_rst_n = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk_out($sformatf("reset%0d", i), 1'b0, 32'h0, 1'b0, 1'b0);
    end
    i_rst_n = 1'b1;

    // Back-to-back table: every vector is checked the cycle after it is presented
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].use_shamt, vecs[i].shamt, vecs[i].value);
      @(negedge i_clk);
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_shifted,
              vecs[i].exp_carry, vecs[i].exp_lost);
    end

    // Zero result, then idle cycles must hold the result with o_valid low
    drive(1'b1, 1'b0, 5'd0, 32'h00000000);
    @(negedge i_clk);
    chk_out("zero", 1'b1, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 5'd3, 32'hFFFFFFFF);
    @(negedge i_clk);
    chk_out("idle0", 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge i_clk);
    chk_out("idle1", 1'b0, 32'h0, 1'b0, 1'b0);

    // Hold after a flagged result as well
    drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
    @(negedge i_clk);
    chk_out("pre_hold", 1'b1, 32'hFFFFFFFC, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 32'h00000001);
    @(negedge i_clk);
    chk_out("hold", 1'b0, 32'hFFFFFFFC, 1'b1, 1'b1);

    // Sweep all run-time amounts with random operands; reset hits at amount 20
    for (int a = 0; a < 32; a++) begin
      v = $urandom;
      if (a == 20) begin
        drive(1'b1, 1'b1, 5'(a), v);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk_out("sweep_rst", 1'b0, 32'h0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
      end
      e_s = v << a;
      e_c = (a == 0) ? 1'b0 : v[32-a];
      e_l = (a == 0) ? 1'b0 : ((v >> (32 - a)) != 32'h0);
      drive(1'b1, 1'b1, 5'(a), v);
      @(negedge i_clk);
      chk_out($sformatf("sweep%0d", a), 1'b1, e_s, e_c, e_l);
    end

    drive(1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge i_clk);
    chk("final_idle.valid", 32'(bus.o_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
